// File: rtl/sha512_pkg.sv
// Shared constants and types for the SHA-512 message padder.
// Core command codes, FSM states and block geometry.
package sha512_pkg;

  localparam logic [3:0] CMD_WR    = 4'h2;
  localparam logic [3:0] CMD_FIRST = 4'h1;
  localparam logic [3:0] CMD_NEXT  = 4'h5;

  localparam int BUSY_BIT        = 3;
  localparam int WORDS_PER_BLOCK = 32;
  localparam int LEN_WORD_IDX    = 28;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PAD,
    LEN,
    START,
    WAIT
  } state_e;

endpackage

// File: rtl/sha512_pad_merge.sv
// Byte-lane merge of the final message word with the 0x80 marker.
// Lanes after the marker are forced to zero.
module sha512_pad_merge (
  input  logic [31:0] i_data,
  input  logic [2:0]  i_bytes,
  input  logic        i_last,
  output logic [31:0] o_word,
  output logic        o_marked
);

  always_comb begin
    o_word   = i_data;
    o_marked = 1'b0;
    if (i_last && (i_bytes < 3'd4)) begin
      o_marked = 1'b1;
      case (i_bytes)
        3'd0:    o_word = 32'h8000_0000;
        3'd1:    o_word = {i_data[31:24], 24'h80_0000};
        3'd2:    o_word = {i_data[31:16], 16'h8000};
        default: o_word = {i_data[31:8], 8'h80};
      endcase
    end
  end

endmodule

// File: rtl/sha512_padder.sv
// Streams a byte message into a SHA-512 core as padded 1024-bit blocks.
// Handles marker, zero fill, 128-bit length and block chaining.
module sha512_padder
  import sha512_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] msg_data_i,
  input  logic [2:0]  msg_bytes_i,
  input  logic        msg_last_i,
  input  logic        msg_valid_i,
  output logic        msg_ready_o,
  output logic [31:0] core_text_o,
  output logic [3:0]  core_cmd_o,
  output logic        core_cmd_w_o,
  input  logic [4:0]  core_cmd_i,
  output logic        done_o
);

  state_e      r_state;
  state_e      w_next;
  logic [4:0]  r_idx;
  logic [63:0] r_cnt;
  logic        r_first;
  logic        r_final;
  logic        r_msg_end;
  logic        r_mark_pend;
  logic        r_busy_q;

  logic        w_busy;
  logic        w_fall;
  logic        w_ready;
  logic        w_accept;
  logic        w_last_idx;
  logic        w_pre_len;
  logic        w_marked;
  logic [31:0] w_merged;
  logic [63:0] w_bits;
  logic        w_unused;

  assign w_busy     = core_cmd_i[BUSY_BIT];
  assign w_unused   = ^{core_cmd_i[4], core_cmd_i[2:0]};
  assign w_fall     = r_busy_q & ~w_busy;
  assign w_ready    = rst_i & ~w_busy &
                      ((r_state == IDLE) || (r_state == DATA));
  assign w_accept   = msg_valid_i & w_ready;
  assign w_last_idx = (r_idx == 5'(WORDS_PER_BLOCK - 1));
  assign w_pre_len  = (r_idx == 5'(LEN_WORD_IDX - 1));
  assign w_bits     = {r_cnt[60:0], 3'b000};

  sha512_pad_merge u_merge (
    .i_data   (msg_data_i),
    .i_bytes  (msg_bytes_i),
    .i_last   (msg_last_i),
    .o_word   (w_merged),
    .o_marked (w_marked)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // A marker written at word 27 leaves room for the length in this block.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DATA: begin
        if (w_accept) begin
          if (w_last_idx)                w_next = START;
          else if (!msg_last_i)          w_next = DATA;
          else if (w_marked && w_pre_len) w_next = LEN;
          else                           w_next = PAD;
        end
      end
      PAD: begin
        if (!w_busy) begin
          if (w_last_idx)     w_next = START;
          else if (w_pre_len) w_next = LEN;
        end
      end
      LEN: begin
        if (!w_busy && w_last_idx) w_next = START;
      end
      START: begin
        if (!w_busy) w_next = WAIT;
      end
      WAIT: begin
        if (w_fall) begin
          if (r_final)        w_next = IDLE;
          else if (r_msg_end) w_next = PAD;
          else                w_next = DATA;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    msg_ready_o  = w_ready;
    core_text_o  = '0;
    core_cmd_o   = '0;
    core_cmd_w_o = 1'b0;
    done_o       = 1'b0;
    case (r_state)
      IDLE, DATA: begin
        if (w_accept) begin
          core_text_o  = w_merged;
          core_cmd_o   = CMD_WR;
          core_cmd_w_o = 1'b1;
        end
      end
      PAD: begin
        if (!w_busy) begin
          core_text_o  = r_mark_pend ? 32'h8000_0000 : 32'h0;
          core_cmd_o   = CMD_WR;
          core_cmd_w_o = 1'b1;
        end
      end
      LEN: begin
        if (!w_busy) begin
          case (r_idx)
            5'd30:   core_text_o = w_bits[63:32];
            5'd31:   core_text_o = w_bits[31:0];
            default: core_text_o = 32'h0;
          endcase
          core_cmd_o   = CMD_WR;
          core_cmd_w_o = 1'b1;
        end
      end
      START: begin
        if (!w_busy) begin
          core_cmd_o   = r_first ? CMD_FIRST : CMD_NEXT;
          core_cmd_w_o = 1'b1;
        end
      end
      WAIT: done_o = w_fall & r_final;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_first     <= 1'b1;
      r_final     <= 1'b0;
      r_msg_end   <= 1'b0;
      r_mark_pend <= 1'b0;
      r_busy_q    <= 1'b0;
    end else begin
      r_busy_q <= w_busy;
      if ((w_next == LEN) && (r_state != LEN)) r_final <= 1'b1;
      case (r_state)
        IDLE, DATA: begin
          if (w_accept) begin
            r_cnt <= ((r_state == IDLE) ? 64'd0 : r_cnt) +
                     {61'd0, msg_bytes_i};
            if (!w_last_idx) r_idx <= r_idx + 5'd1;
            if (msg_last_i) begin
              r_msg_end   <= 1'b1;
              r_mark_pend <= ~w_marked;
            end
          end
        end
        PAD: begin
          if (!w_busy) begin
            r_mark_pend <= 1'b0;
            if (!w_last_idx) r_idx <= r_idx + 5'd1;
          end
        end
        LEN: begin
          if (!w_busy && !w_last_idx) r_idx <= r_idx + 5'd1;
        end
        START: begin
          if (!w_busy) begin
            r_idx   <= '0;
            r_first <= 1'b0;
          end
        end
        WAIT: begin
          if (w_fall && r_final) begin
            r_first   <= 1'b1;
            r_final   <= 1'b0;
            r_msg_end <= 1'b0;
            r_cnt     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha512_padder.sv
// Bench for sha512_padder: behavioural core with a busy window and a
// reference padder that fills a queue of expected blocks.
module tb_sha512_padder;

  localparam logic [3:0] C_WR    = 4'h2;
  localparam logic [3:0] C_FIRST = 4'h1;
  localparam logic [3:0] C_NEXT  = 4'h5;

  typedef struct packed {
    logic [3:0]        cmd;
    logic [31:0][31:0] w;
  } blk_t;
  typedef byte unsigned bq_t[$];

  logic        clk;
  logic        rst_i;
  logic [31:0] msg_data_i;
  logic [2:0]  msg_bytes_i;
  logic        msg_last_i;
  logic        msg_valid_i;
  logic        msg_ready_o;
  logic [31:0] core_text_o;
  logic [3:0]  core_cmd_o;
  logic        core_cmd_w_o;
  logic [4:0]  core_cmd_i;
  logic        done_o;

  int   checks;
  int   errors;
  int   busy_cnt;
  int   busy_len;
  int   widx;
  int   done_cnt;
  blk_t exp_q[$];
  blk_t obs;
  blk_t last_obs;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign core_cmd_i = {1'b0, busy_cnt > 0, 3'b000};

  sha512_padder dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .msg_data_i   (msg_data_i),
    .msg_bytes_i  (msg_bytes_i),
    .msg_last_i   (msg_last_i),
    .msg_valid_i  (msg_valid_i),
    .msg_ready_o  (msg_ready_o),
    .core_text_o  (core_text_o),
    .core_cmd_o   (core_cmd_o),
    .core_cmd_w_o (core_cmd_w_o),
    .core_cmd_i   (core_cmd_i),
    .done_o       (done_o)
  );

  // Reference SHA-512 padding over a byte stream.
  task automatic push_exp(input bq_t m);
    bq_t         p;
    blk_t        e;
    logic [63:0] bits;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 128 != 112) p.push_back(8'h00);
    bits = 64'(m.size()) << 3;
    for (int i = 0; i < 8; i++) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    for (int b = 0; b < p.size() / 128; b++) begin
      e.cmd = (b == 0) ? C_FIRST : C_NEXT;
      for (int i = 0; i < 32; i++)
        e.w[i] = {p[b*128+4*i], p[b*128+4*i+1],
                  p[b*128+4*i+2], p[b*128+4*i+3]};
      exp_q.push_back(e);
    end
  endtask

  // One clock: sample at negedge+1, run core model and scoreboard.
  task automatic cycle(output bit acc);
    bit   start;
    blk_t e;
    start = 1'b0;
    #1;
    acc = (msg_valid_i === 1'b1) && (msg_ready_o === 1'b1);
    if (busy_cnt > 0) begin
      checks++;
      if (msg_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL ready_busy got %b want 0", msg_ready_o);
      end
    end
    if (core_cmd_w_o === 1'b1) begin
      checks++;
      if (busy_cnt > 0) begin
        errors++;
        $display("FAIL cmd_w_busy got 1 want 0 cmd %h", core_cmd_o);
      end
      if (core_cmd_o === C_WR) begin
        if (widx < 32) obs.w[widx] = core_text_o;
        widx++;
      end else begin
        start = 1'b1;
        obs.cmd = core_cmd_o;
        last_obs = obs;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_block got cmd %h want none", core_cmd_o);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (obs.cmd !== e.cmd) begin
            errors++;
            $display("FAIL start_cmd got %h want %h", obs.cmd, e.cmd);
          end
          checks++;
          if (widx != 32) begin
            errors++;
            $display("FAIL wr_count got %0d want 32", widx);
          end
          for (int i = 0; i < 32; i++) begin
            checks++;
            if (obs.w[i] !== e.w[i]) begin
              errors++;
              $display("FAIL word%0d got %h want %h", i, obs.w[i], e.w[i]);
            end
          end
        end
        widx = 0;
      end
    end
    if (done_o === 1'b1) done_cnt++;
    @(posedge clk);
    #1;
    if (start) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] nb,
                           input logic last);
    bit acc;
    int n;
    msg_valid_i = 1'b1;
    msg_data_i  = d;
    msg_bytes_i = nb;
    msg_last_i  = last;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 500) begin
      cycle(acc);
      n++;
    end
    msg_valid_i = 1'b0;
    msg_last_i  = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout got none want accept");
    end
  endtask

  task automatic send_msg(input bq_t m, input byte unsigned fill);
    int          n;
    int          nb;
    logic [31:0] d;
    n = m.size();
    push_exp(m);
    done_cnt = 0;
    if (n == 0) send_word(32'h0, 3'd0, 1'b1);
    for (int k = 0; k < (n + 3) / 4; k++) begin
      nb = (n - 4*k > 4) ? 4 : n - 4*k;
      for (int j = 0; j < 4; j++)
        d[31-8*j -: 8] = (j < nb) ? m[4*k+j] : fill;
      send_word(d, 3'(nb), (4*k + nb) == n);
    end
  endtask

  task automatic wait_done();
    bit acc;
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      cycle(acc);
      n++;
    end
    repeat (3) cycle(acc);
  endtask

  function automatic bq_t mk(input int n, input int seed);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'((i * 7 + seed) & 255));
    return q;
  endfunction

  task automatic test_reset();
    rst_i = 1'b0;
    msg_valid_i = 1'b1;
    msg_last_i = 1'b1;
    #1;
    checks++;
    if ({msg_ready_o, core_cmd_w_o, done_o, core_cmd_o, core_text_o} !== '0)
    begin
      errors++;
      $display("FAIL reset_outs got r%b w%b d%b c%h t%h want 0",
               msg_ready_o, core_cmd_w_o, done_o, core_cmd_o, core_text_o);
    end
    @(negedge clk);
    msg_valid_i = 1'b0;
    msg_last_i = 1'b0;
    rst_i = 1'b1;
    #1;
    checks++;
    if (msg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b want 1", msg_ready_o);
    end
    @(negedge clk);
  endtask

  task automatic test_abc(input string name);
    bq_t m;
    m = {8'h61, 8'h62, 8'h63};
    send_msg(m, 8'h00);
    wait_done();
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s_done got %0d want 1", name, done_cnt);
    end
    checks++;
    if (last_obs.w[0] !== 32'h6162_6380 || last_obs.w[31] !== 32'h18) begin
      errors++;
      $display("FAIL %s_words got %h/%h want 61626380/00000018",
               name, last_obs.w[0], last_obs.w[31]);
    end
    checks++;
    if (exp_q.size() != 0 || last_obs.cmd !== C_FIRST) begin
      errors++;
      $display("FAIL %s_blocks got %0d left cmd %h want 0 left cmd 1",
               name, exp_q.size(), last_obs.cmd);
    end
  endtask

  task automatic test_empty();
    bq_t m;
    send_msg(m, 8'h00);
    wait_done();
    checks++;
    if (done_cnt != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL empty_done got %0d/%0d want 1/0",
               done_cnt, exp_q.size());
    end
    checks++;
    if (last_obs.w[0] !== 32'h8000_0000 || last_obs.w[31] !== 32'h0) begin
      errors++;
      $display("FAIL empty_words got %h/%h want 80000000/0",
               last_obs.w[0], last_obs.w[31]);
    end
  endtask

  task automatic test_112();
    send_msg(mk(112, 3), 8'hEE);
    wait_done();
    checks++;
    if (done_cnt != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL len112_done got %0d/%0d want 1/0",
               done_cnt, exp_q.size());
    end
    checks++;
    if (last_obs.cmd !== C_NEXT || last_obs.w[31] !== 32'h380) begin
      errors++;
      $display("FAIL len112_last got %h/%h want 5/00000380",
               last_obs.cmd, last_obs.w[31]);
    end
  endtask

  task automatic test_128_busy();
    busy_len = 20;
    send_msg(mk(128, 9), 8'hEE);
    wait_done();
    busy_len = 3;
    checks++;
    if (done_cnt != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL len128_done got %0d/%0d want 1/0",
               done_cnt, exp_q.size());
    end
    checks++;
    if (last_obs.w[0] !== 32'h8000_0000 || last_obs.w[31] !== 32'h400) begin
      errors++;
      $display("FAIL len128_last got %h/%h want 80000000/00000400",
               last_obs.w[0], last_obs.w[31]);
    end
  endtask

  task automatic test_back_to_back();
    int lens[7] = '{1, 55, 111, 117, 120, 125, 200};
    foreach (lens[i]) begin
      busy_len = int'($urandom_range(1, 6));
      send_msg(mk(lens[i], i), 8'hEE);
      wait_done();
      checks++;
      if (done_cnt != 1 || exp_q.size() != 0) begin
        errors++;
        $display("FAIL len%0d_done got %0d/%0d want 1/0",
                 lens[i], done_cnt, exp_q.size());
      end
    end
    busy_len = 3;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 10; k++)
      send_word(32'hA5A5_0000 + 32'(k), 3'd4, 1'b0);
    rst_i = 1'b0;
    msg_valid_i = 1'b1;
    msg_bytes_i = 3'd4;
    #1;
    checks++;
    if ({msg_ready_o, core_cmd_w_o, done_o, core_cmd_o, core_text_o} !== '0)
    begin
      errors++;
      $display("FAIL midreset_outs got r%b w%b d%b c%h t%h want 0",
               msg_ready_o, core_cmd_w_o, done_o, core_cmd_o, core_text_o);
    end
    @(negedge clk);
    msg_valid_i = 1'b0;
    widx = 0;
    busy_cnt = 0;
    rst_i = 1'b1;
    #1;
    checks++;
    if (msg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready got %b want 1", msg_ready_o);
    end
    @(negedge clk);
    test_abc("abc_after_reset");
  endtask

  initial begin
    rst_i       = 1'b0;
    msg_data_i  = '0;
    msg_bytes_i = '0;
    msg_last_i  = 1'b0;
    msg_valid_i = 1'b0;
    checks   = 0;
    errors   = 0;
    busy_cnt = 0;
    busy_len = 3;
    widx     = 0;
    done_cnt = 0;
    obs      = '0;
    last_obs = '0;
    @(negedge clk);
    test_reset();
    test_abc("abc");
    test_empty();
    test_112();
    test_128_busy();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha512_padder.md
SHA512_PADDER -- requirements
Module: sha512_padder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as the codebase names them.
REQ-002 Ports, as name  direction  width  meaning:
- clk_i  in  1  clock
- rst_i  in  1  async active-low reset
- msg_data_i  in  32  message word, big-endian; byte 0 = [31:24]
- msg_bytes_i  in  3  valid bytes in the word, 1..4; 0 legal only with msg_last_i (empty final word)
- msg_last_i  in  1  final word of the message
- msg_valid_i  in  1  word offered
- msg_ready_o  out  1  word accepted when msg_valid_i & msg_ready_o
- core_text_o  out  32  word to the sha512 core text_i
- core_cmd_o  out  4  command to the core cmd_i
- core_cmd_w_o  out  1  command strobe to the core cmd_w_i
- core_cmd_i  in  5  status from the core cmd_o; bit 3 = busy
- done_o  out  1  one-cycle pulse when the last block's hash completes

Function
REQ-003 Core command encodings SHALL be: CMD_WR = 4'h2 (load core_text_o into the next word slot), CMD_FIRST = 4'h1 (init and hash), CMD_NEXT = 4'h5 (hash chained).
REQ-004 Each 1024-bit block SHALL be sent as 32 consecutive CMD_WR strobes, word index 0..31, followed by one start strobe.
REQ-005 The start strobe SHALL be CMD_FIRST for the first block of a message and CMD_NEXT otherwise.
REQ-006 FSM states SHALL be IDLE, DATA, PAD, LEN, START, WAIT.
- IDLE->DATA on the first accepted word.
- DATA->PAD on an accepted word with msg_last_i.
- PAD->LEN when the word index is 28.
- LEN->START after word index 31.
- START->WAIT for one cycle.
- WAIT->IDLE or WAIT->DATA/PAD when busy falls.
REQ-007 msg_ready_o SHALL be 1 only in IDLE or DATA while the word index is below 32; an accepted word is written to the core in the same cycle.
REQ-008 The padding marker byte 0x80 SHALL occupy the byte immediately after the last message byte, inside the last word when msg_bytes_i < 4, otherwise as word 0x80000000 in PAD. Remaining bytes SHALL be zero.
REQ-009 A 64-bit byte counter SHALL accumulate msg_bytes_i; the length field is bits = count<<3.
- Word 28 = 0, word 29 = 0.
- Word 30 = bits[63:32], word 31 = bits[31:0].
REQ-010 If the marker lands at word index 28..31, the remainder of the block SHALL be zero-filled and started. The next block SHALL be zeros to index 27, then the length.
REQ-011 On a full 32-word block in DATA without msg_last_i, the block SHALL be started and the FSM SHALL wait for busy to fall, with msg_ready_o low, before returning to DATA.
REQ-012 core_cmd_w_o SHALL never assert while core busy is 1.
REQ-013 done_o SHALL pulse for exactly one cycle on the busy 1->0 edge after the final block, and the FSM SHALL then return to IDLE.
REQ-014 The word index SHALL be 5 bits and wrap 31->0 only on the block start.

Reset
REQ-015 On reset, including mid-operation, the FSM SHALL go to IDLE and the index and byte counter SHALL clear.
REQ-016 During reset all outputs SHALL be 0, including msg_ready_o.
REQ-017 After reset is released, msg_ready_o SHALL be 1 in IDLE.

Structure
REQ-018 A package sha512_pkg SHALL hold the CMD_* constants, the FSM state enum, BUSY_BIT = 3, WORDS_PER_BLOCK = 32 and LEN_WORD_IDX = 28.
REQ-019 The byte-lane marker/mask merge SHALL be a combinational sub-module, sha512_pad_merge.

Verification
REQ-020 "abc" (0x61626300, bytes = 3, last):
- word 0 = 0x61626380.
- words 1..30 = 0, word 31 = 0x00000018.
- One CMD_FIRST, then done_o.
REQ-021 Empty message (bytes = 0, last):
- word 0 = 0x80000000, all other words zero.
- One block, then done_o.
REQ-022 112-byte message:
- word 28 = 0x80000000; CMD_FIRST.
- Second block zeros with word 31 = 0x00000380; CMD_NEXT.
REQ-023 128-byte message, core busy held 20 cycles:
- msg_ready_o low for the full busy period.
- No core_cmd_w_o while busy.
- Second block = 0x80000000, zeros, word 31 = 0x00000400.
REQ-024 Reset asserted mid-block at word index 10:
- All outputs 0 during reset.
- After release, a new "abc" produces the REQ-020 result with CMD_FIRST.
